// File: rtl/semaforo_pkg.sv
// Shared types and lamp encodings for the two-street intersection phase scheduler.
package semaforo_pkg;

   typedef enum logic [2:0] {
      ALL_RED   = 3'd0,
      S1_GREEN  = 3'd1,
      S1_YELLOW = 3'd2,
      S2_GREEN  = 3'd3,
      S2_YELLOW = 3'd4,
      PED_GREEN = 3'd5
   } phase_t;

   localparam logic [2:0] LAMP_RED = 3'b100;
   localparam logic [2:0] LAMP_YEL = 3'b010;
   localparam logic [2:0] LAMP_GRN = 3'b001;
   localparam logic [1:0] PED_RED  = 2'b10;
   localparam logic [1:0] PED_GRN  = 2'b01;

endpackage

// File: rtl/semaforo_scheduler_phase_timer.sv
// Generic down-counter: load wins over hold, hold freezes, otherwise counts down to zero and stops.
module phase_timer #(
   parameter int            CW   = 4,
   parameter logic [CW-1:0] INIT = '0
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          hold,
   output logic          done
);

   logic [CW-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= INIT;
      else if (load)
         count <= load_val;
      else if (!hold && count != '0)
         count <= count - CW'(1);
   end

   assign done = (count == '0);

endmodule

// File: rtl/semaforo_scheduler.sv
// Intersection phase sequencer: street 1/2 and pedestrian phases separated by all-red clearance,
// with latched pedestrian requests and street-1 emergency preemption. Lamps are Moore-decoded.
module semaforo_scheduler
   import semaforo_pkg::*;
#(
   parameter int GREEN1_CYC = 4,
   parameter int GREEN2_CYC = 4,
   parameter int YELLOW_CYC = 2,
   parameter int PED_CYC    = 5,
   parameter int ALLRED_CYC = 1,
   parameter int CW         = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ped_btn_1,
   input  logic       ped_btn_2,
   input  logic       emerg_req,
   output logic [2:0] light_1,
   output logic [2:0] light_2,
   output logic [1:0] ped_light,
   output logic       ped_wait,
   output logic [2:0] phase
);

   localparam int MAX_G   = (GREEN1_CYC > GREEN2_CYC) ? GREEN1_CYC : GREEN2_CYC;
   localparam int MAX_YP  = (YELLOW_CYC > PED_CYC) ? YELLOW_CYC : PED_CYC;
   localparam int MAX_GYP = (MAX_G > MAX_YP) ? MAX_G : MAX_YP;
   localparam int MAX_DUR = (MAX_GYP > ALLRED_CYC) ? MAX_GYP : ALLRED_CYC;

   if ((MAX_DUR - 1) >= (1 << CW)) begin : g_cw_check
      $error("CW is too narrow to hold the longest phase duration minus one");
   end

   phase_t        state, nxt;
   logic          ped_pending;
   logic          last_s1;      // 1: street 1 was the last street served
   logic          load, hold, done;
   logic [CW-1:0] load_val;

   phase_timer #(
      .CW   (CW),
      .INIT (CW'(ALLRED_CYC - 1))
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .load_val (load_val),
      .hold     (hold),
      .done     (done)
   );

   always_comb begin
      nxt  = state;
      hold = 1'b0;
      unique case (state)
         ALL_RED: begin
            if (done) begin
               if (emerg_req)        nxt = S1_GREEN;
               else if (ped_pending) nxt = PED_GREEN;
               else if (last_s1)     nxt = S2_GREEN;
               else                  nxt = S1_GREEN;
            end
         end
         // Emergency freezes street-1 green; the unexpired remainder runs after release.
         S1_GREEN: begin
            if (emerg_req)  hold = 1'b1;
            else if (done)  nxt  = S1_YELLOW;
         end
         S1_YELLOW: if (done) nxt = ALL_RED;
         S2_GREEN:  if (done || emerg_req) nxt = S2_YELLOW;
         S2_YELLOW: if (done) nxt = ALL_RED;
         PED_GREEN: if (done) nxt = ALL_RED;
         default:   nxt = ALL_RED;
      endcase
   end

   assign load = (nxt != state);

   always_comb begin
      unique case (nxt)
         S1_GREEN:             load_val = CW'(GREEN1_CYC - 1);
         S2_GREEN:             load_val = CW'(GREEN2_CYC - 1);
         S1_YELLOW, S2_YELLOW: load_val = CW'(YELLOW_CYC - 1);
         PED_GREEN:            load_val = CW'(PED_CYC - 1);
         default:              load_val = CW'(ALLRED_CYC - 1);
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ALL_RED;
         ped_pending <= 1'b0;
         last_s1     <= 1'b0;
      end else begin
         state <= nxt;
         if (state != PED_GREEN && nxt == PED_GREEN)
            ped_pending <= 1'b0;
         else if ((ped_btn_1 || ped_btn_2) && state != PED_GREEN)
            ped_pending <= 1'b1;
         if (state != S1_GREEN && nxt == S1_GREEN)
            last_s1 <= 1'b1;
         else if (state != S2_GREEN && nxt == S2_GREEN)
            last_s1 <= 1'b0;
      end
   end

   always_comb begin
      light_1   = LAMP_RED;
      light_2   = LAMP_RED;
      ped_light = PED_RED;
      unique case (state)
         S1_GREEN:  light_1   = LAMP_GRN;
         S1_YELLOW: light_1   = LAMP_YEL;
         S2_GREEN:  light_2   = LAMP_GRN;
         S2_YELLOW: light_2   = LAMP_YEL;
         PED_GREEN: ped_light = PED_GRN;
         default: ;
      endcase
   end

   assign ped_wait = ped_pending;
   assign phase    = state;

endmodule
